// File: rtl/tt_capture_scope.sv
// tt_capture_scope: armed capture scope over a WIDTH-bit bus.
// A DEPTH-entry ring keeps sampling until a masked trigger, retains PRE
// pre-trigger samples, then a valid/ready port streams the window out.
// Optional macro CAPTURE_EDGE_TRIG_EN: trigger on a rising match only
// (match now, no match on the previously stored sample).
module tt_capture_scope #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PRE   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       state,
  output logic             triggered
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int POST_N = DEPTH - PRE - 1;
  localparam logic [CW-1:0] PRE_C   = CW'(PRE);
  localparam logic [CW-1:0] POST_C  = CW'(POST_N);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READ} st_e;

  st_e             st_q, st_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_ptr_q, trig_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            trig_q, trig_d, prev_q, prev_d;
  logic            store, match, fire;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign match   = ((sample_in ^ trig_value) & trig_mask) == '0;
  assign cnt_inc = cnt_q + CW'(1);
`ifdef CAPTURE_EDGE_TRIG_EN
  assign fire = match & ~prev_q;
`else
  assign fire = match;
`endif

  // Next-state: sequencing, pointer/counter updates and store enable.
  always_comb begin
    st_d       = st_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    trig_d     = trig_q;
    prev_d     = prev_q;
    store      = 1'b0;
    if (ena) begin
      if (abort) begin
        st_d     = S_IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        trig_d   = 1'b0;
        prev_d   = 1'b0;
      end else begin
        case (st_q)
          S_IDLE: if (arm) begin
            st_d   = (PRE == 0) ? S_ARMED : S_FILL;
            cnt_d  = '0;
            trig_d = 1'b0;
            prev_d = 1'b0;
          end
          S_FILL: begin
            store    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_inc;
            if (cnt_inc == PRE_C) st_d = S_ARMED;
          end
          S_ARMED: begin
            store    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fire) begin
              trig_ptr_d = wr_ptr_q;
              trig_d     = 1'b1;
              cnt_d      = '0;
              // With no post samples the window is complete at the trigger.
              if (POST_N == 0) begin
                st_d     = S_READ;
                rd_ptr_d = wr_ptr_q - AW'(PRE);
              end else begin
                st_d = S_POST;
              end
            end
          end
          S_POST: begin
            store    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_inc;
            if (cnt_inc == POST_C) begin
              st_d     = S_READ;
              rd_ptr_d = trig_ptr_q - AW'(PRE);
              cnt_d    = '0;
            end
          end
          S_READ: if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_inc;
            if (cnt_inc == DEPTH_C) begin
              st_d   = S_IDLE;
              trig_d = 1'b0;
              cnt_d  = '0;
            end
          end
          default: st_d = S_IDLE;
        endcase
        // Edge detection compares against the last stored sample only.
        if (store) prev_d = match;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      prev_q     <= prev_d;
    end
  end

  // Sample ring; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (rst_n && store) mem_q[wr_ptr_q] <= sample_in;
  end

  assign rd_valid  = (st_q == S_READ);
  assign rd_data   = mem_q[rd_ptr_q];
  assign state     = (st_q == S_READ) ? 2'd0 : st_q[1:0];
  assign triggered = trig_q;
endmodule

// File: tb/tb_tt_capture_scope.sv
module tb_tt_capture_scope;
  localparam int W = 8, D = 16, P = 4;

  logic clk = 1'b0;
  logic rst_n, ena, arm, arm0, abort, rd_ready;
  logic [W-1:0] sample_in, trig_mask, trig_value;
  logic rv_a, rv_b, tg_a, tg_b;
  logic [W-1:0] rd_a, rd_b;
  logic [1:0] st_a, st_b;
  bit sel;
  logic rv_s, tg_s;
  logic [W-1:0] rd_s;
  logic [1:0] st_s;
  int checks = 0, passed = 0;
  logic [W-1:0] stim [256];

  always #5 clk = ~clk;

  tt_capture_scope #(.WIDTH(W), .DEPTH(D), .PRE(P)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .arm(arm), .abort(abort),
    .sample_in(sample_in), .trig_mask(trig_mask), .trig_value(trig_value),
    .rd_ready(rd_ready), .rd_valid(rv_a), .rd_data(rd_a), .state(st_a),
    .triggered(tg_a));

  tt_capture_scope #(.WIDTH(W), .DEPTH(D), .PRE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .arm(arm0), .abort(abort),
    .sample_in(sample_in), .trig_mask(trig_mask), .trig_value(trig_value),
    .rd_ready(rd_ready), .rd_valid(rv_b), .rd_data(rd_b), .state(st_b),
    .triggered(tg_b));

  assign rv_s = sel ? rv_b : rv_a;
  assign tg_s = sel ? tg_b : tg_a;
  assign rd_s = sel ? rd_b : rd_a;
  assign st_s = sel ? st_b : st_a;

  function automatic bit is_match(input logic [W-1:0] v);
    return ((v ^ trig_value) & trig_mask) == '0;
  endfunction

  // Index of the stored sample that fires the trigger, from the rules alone.
  function automatic int find_trig(input int pre);
    for (int t = pre; t < 200; t++) begin
      bit prevm;
      prevm = (t > 0) ? is_match(stim[t-1]) : 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
      if (is_match(stim[t]) && !prevm) return t;
`else
      if (is_match(stim[t])) return t;
`endif
    end
    return -1;
  endfunction

  // Expected {state, triggered, rd_valid} after i stores.
  function automatic logic [3:0] exp_view(input int i, input int t, input int pre);
    if (i < pre)              return {2'd1, 1'b0, 1'b0};
    else if (i <= t)          return {2'd2, 1'b0, 1'b0};
    else if (i < t + D - pre) return {2'd3, 1'b1, 1'b0};
    else                      return {2'd0, 1'b1, 1'b1};
  endfunction

  task automatic capture(input bit b, input int pre, input int rmode,
                         input int abort_after, input bit gap);
    int t, i, pops;
    bit done;
    logic [3:0] e;
    sel = b;
    t = find_trig(pre);
    checks++;
    if (t < 0) begin
      $display("FAIL model_trigger got=none required=found");
      return;
    end
    passed++;
    @(negedge clk);
    if (b) arm0 = 1'b1; else arm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0; arm0 = 1'b0;
    i = 0; done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      e = exp_view(i, t, pre);
      checks++;
      if ({st_s, tg_s, rv_s} !== e)
        $display("FAIL capture_view i=%0d got=%h required=%h", i, {st_s, tg_s, rv_s}, e);
      else passed++;
      if (i == t + D - pre) begin done = 1; break; end
      if (abort_after >= 0 && i == t + 1 + abort_after) begin
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({st_s, tg_s, rv_s} !== 4'h0)
          $display("FAIL abort_view got=%h required=0", {st_s, tg_s, rv_s});
        else passed++;
        return;
      end
      if (gap && i == pre + 1) begin
        ena = 1'b0;
        sample_in = trig_value;
        repeat (2) begin
          @(posedge clk); @(negedge clk);
          checks++;
          if ({st_s, tg_s, rv_s} !== e)
            $display("FAIL ena_hold got=%h required=%h", {st_s, tg_s, rv_s}, e);
          else passed++;
        end
        ena = 1'b1;
      end
      sample_in = stim[i];
      i++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (!done) begin
      $display("FAIL capture_timeout got=%0d required=%0d", i, t + D - pre);
      return;
    end
    passed++;
    pops = 0;
    for (int cyc = 0; cyc < 4 * D && pops < D; cyc++) begin
      checks++;
      if (rv_s !== 1'b1 || rd_s !== stim[t - pre + pops])
        $display("FAIL readout pop=%0d got=%b/%h required=1/%h",
                 pops, rv_s, rd_s, stim[t - pre + pops]);
      else passed++;
      rd_ready = (rmode == 0) ? 1'b1 : (cyc % 2 == 0);
      @(posedge clk);
      if (rd_ready) pops++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++;
    if (pops != D) $display("FAIL readout_count got=%0d required=%0d", pops, D);
    else passed++;
    checks++;
    if ({st_s, tg_s, rv_s} !== 4'h0)
      $display("FAIL post_readout got=%h required=0", {st_s, tg_s, rv_s});
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; arm = 1'b0; arm0 = 1'b0; abort = 1'b0;
    rd_ready = 1'b0; sample_in = '0; trig_mask = '0; trig_value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({st_a, tg_a, rv_a, st_b, tg_b, rv_b} !== 8'h00)
      $display("FAIL reset got=%h required=00", {st_a, tg_a, rv_a, st_b, tg_b, rv_b});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic set_counter(input logic [W-1:0] base);
    for (int i = 0; i < 256; i++) stim[i] = base + W'(i);
  endtask

  task automatic test_level();
    trig_mask = 8'hFF; trig_value = 8'h20; set_counter(8'h10);
    capture(0, P, 0, -1, 0);
  endtask

  task automatic test_back_pressure();
    trig_mask = 8'hFF; trig_value = 8'h20; set_counter(8'h10);
    capture(0, P, 1, -1, 0);
  endtask

  task automatic test_mask();
    trig_mask = 8'hF0; trig_value = 8'hA0;
    for (int i = 0; i < 256; i++) stim[i] = {4'($urandom_range(0, 9)), 4'($urandom)};
    stim[4] = 8'h00; stim[5] = 8'h11; stim[6] = 8'hA7;
    capture(0, P, 0, -1, 0);
  endtask

  task automatic test_abort();
    trig_mask = 8'hFF; trig_value = 8'h20; set_counter(8'h10);
    capture(0, P, 0, 3, 0);
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    checks++;
    if ({st_a, tg_a, rv_a} !== 4'h0)
      $display("FAIL abort_beats_arm got=%h required=0", {st_a, tg_a, rv_a});
    else passed++;
    set_counter(8'h40); trig_value = 8'h5A;
    capture(0, P, 0, -1, 0);
  endtask

  task automatic test_pre0_wrap();
    trig_mask = 8'hFF; trig_value = 8'h38; set_counter(8'h10);
    capture(1, 0, 0, -1, 0);
  endtask

  task automatic test_edge();
    trig_mask = 8'hFF; trig_value = 8'h20;
    for (int i = 0; i < 256; i++) stim[i] = {4'($urandom_range(3, 15)), 4'($urandom)};
    for (int i = 0; i < 5; i++) stim[i] = 8'h20;
    stim[5] = 8'h00; stim[6] = 8'h00; stim[7] = 8'h20;
    capture(0, P, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 20; k++) begin
        trig_mask  = 8'($urandom) & 8'($urandom) & 8'($urandom);
        trig_value = 8'($urandom);
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        if (find_trig(P) >= 0) break;
      end
      capture(0, P, n % 2, -1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_back_pressure();
    test_mask();
    test_abort();
    test_pre0_wrap();
    test_edge();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
